// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter: FSM states,
// command field positions and the DE2 codec/decoder slave addresses.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EVAL,
    RELEASE,
    BACKOFF,
    RESP
  } arbState_t;

  // Command layout: {slave[7:0], sub[7:0], data[7:0]}
  localparam int SLAVE_MSB = 23;
  localparam int SLAVE_LSB = 16;
  localparam int SUB_MSB   = 15;
  localparam int SUB_LSB   = 8;
  localparam int DAT_MSB   = 7;
  localparam int DAT_LSB   = 0;

  localparam logic [7:0] CODEC_SLAVE_ADDR   = 8'h34;
  localparam logic [7:0] DECODER_SLAVE_ADDR = 8'h40;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after
// the pointer (wrapping) wins; returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] reqVec,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grantOh,
  output logic [PTR_W-1:0] grantIdx,
  output logic             grantAny
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!grantAny && reqVec[cand]) begin
        grantAny      = 1'b1;
        grantOh[cand] = 1'b1;
        grantIdx      = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one DE2 I2C write controller between N_REQ command sources.
// Define I2C_ARB_RETRY_EN to build NACK retry with backoff; otherwise any NACK fails at once.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 24,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 1024,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_done,
  output logic [N_REQ-1:0]        rsp_err,
  output logic                    busy,
  output logic [DATA_W-1:0]       oI2C_DATA,
  output logic                    oI2C_GO,
  input  logic                    iI2C_END,
  input  logic                    iI2C_ACK
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  arbState_t        state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grantIdx;
  logic [N_REQ-1:0] grantOh;
  logic [N_REQ-1:0] ownerOh;
  logic             grantAny;
  logic             endSync_p0, endSync_p1;
  logic             ackSync_p0, ackSync_p1;
  logic             ackCap;
  logic [TO_W-1:0]  toCnt;

`ifdef I2C_ARB_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BO_W  = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  logic [RTY_W-1:0] retryCnt;
  logic [BO_W-1:0]  boCnt;
`else
  logic unusedRetryCfg;
  assign unusedRetryCfg = ^{MAX_RETRY, BACKOFF_CYC};
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) uRr (
    .reqVec   (req_valid),
    .ptr      (ptr),
    .grantOh  (grantOh),
    .grantIdx (grantIdx),
    .grantAny (grantAny)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      ptr        <= PTR_W'(N_REQ - 1);
      ownerOh    <= '0;
      ackCap     <= 1'b0;
      toCnt      <= '0;
      endSync_p0 <= 1'b0;
      endSync_p1 <= 1'b0;
      ackSync_p0 <= 1'b0;
      ackSync_p1 <= 1'b0;
      req_ready  <= '0;
      rsp_done   <= '0;
      rsp_err    <= '0;
      busy       <= 1'b0;
      oI2C_DATA  <= '0;
      oI2C_GO    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
      retryCnt   <= '0;
      boCnt      <= '0;
`endif
    end else begin
      // stage p0/p1: slow-domain END/ACK synchronisers
      endSync_p0 <= iI2C_END;
      endSync_p1 <= endSync_p0;
      ackSync_p0 <= iI2C_ACK;
      ackSync_p1 <= ackSync_p0;

      req_ready <= '0;
      rsp_done  <= '0;
      rsp_err   <= '0;
      if (toCnt != TO_LIMIT) toCnt <= toCnt + 1'b1;

      case (state)
        IDLE: begin
          if (grantAny) begin
            oI2C_DATA <= req_data[grantIdx*DATA_W +: DATA_W];
            req_ready <= grantOh;
            ownerOh   <= grantOh;
            ptr       <= grantIdx;
            oI2C_GO   <= 1'b1;
            busy      <= 1'b1;
            toCnt     <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A stale END already high on entry counts as the completion.
          if (endSync_p1) begin
            oI2C_GO <= 1'b0;
            state   <= EVAL;
          end else if (toCnt == TO_LIMIT) begin
            oI2C_GO  <= 1'b0;
            rsp_done <= ownerOh;
            rsp_err  <= ownerOh;
            state    <= RESP;
          end
        end
        EVAL: begin
          ackCap <= ackSync_p1;
          toCnt  <= '0;
          state  <= RELEASE;
        end
        RELEASE: begin
          if (!endSync_p1) begin
            if (!ackCap) begin
              rsp_done <= ownerOh;
              state    <= RESP;
            end
`ifdef I2C_ARB_RETRY_EN
            else if (retryCnt < RTY_W'(MAX_RETRY)) begin
              retryCnt <= retryCnt + 1'b1;
              boCnt    <= '0;
              state    <= BACKOFF;
            end
`endif
            else begin
              rsp_done <= ownerOh;
              rsp_err  <= ownerOh;
              state    <= RESP;
            end
          end else if (toCnt == TO_LIMIT) begin
            rsp_done <= ownerOh;
            rsp_err  <= ownerOh;
            state    <= RESP;
          end
        end
`ifdef I2C_ARB_RETRY_EN
        BACKOFF: begin
          if (boCnt == BO_W'(BACKOFF_CYC - 1)) begin
            oI2C_GO <= 1'b1;
            toCnt   <= '0;
            state   <= ISSUE;
          end else begin
            boCnt <= boCnt + 1'b1;
          end
        end
`endif
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef I2C_ARB_RETRY_EN
          retryCnt <= '0;
`endif
        end
        default: begin
          oI2C_GO <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: scripted I2C controller model plus an
// outcome-level reference model (grant order, GO pulse count, error result).
module tb_i2c_cmd_arbiter;
  import i2c_arb_pkg::*;

  localparam int N_REQ       = 2;
  localparam int DATA_W      = 24;
  localparam int MAX_RETRY   = 3;
  localparam int BACKOFF_CYC = 16;
  localparam int TIMEOUT_CYC = 300;

  logic                    iCLK = 1'b0;
  logic                    iRST;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_done;
  logic [N_REQ-1:0]        rsp_err;
  logic                    busy;
  logic [DATA_W-1:0]       oI2C_DATA;
  logic                    oI2C_GO;
  logic                    iI2C_END;
  logic                    iI2C_ACK;

  int nAsserts = 0;
  int nFail    = 0;
  int mPtr;

  // controller script, written by the main process
  int ctlEpoch;
  int ctlNacks;
  int ctlLat;
  bit ctlHang;
  // controller private state
  int ctlSeenEpoch;
  int ctlAttempts;
  int ctlN;
  bit ctlNk;

  i2c_cmd_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .MAX_RETRY   (MAX_RETRY),
    .BACKOFF_CYC (BACKOFF_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .oI2C_DATA (oI2C_DATA),
    .oI2C_GO   (oI2C_GO),
    .iI2C_END  (iI2C_END),
    .iI2C_ACK  (iI2C_ACK)
  );

  always #5 iCLK = ~iCLK;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // I2C write controller: END after ctlLat cycles of GO, NACK for the first
  // ctlNacks attempts of a command, never END when hanging; END low after GO low.
  initial begin : ctlModel
    iI2C_END     = 1'b0;
    iI2C_ACK     = 1'b0;
    ctlSeenEpoch = -1;
    ctlAttempts  = 0;
    forever begin
      @(posedge iCLK);
      if (oI2C_GO) begin
        if (ctlSeenEpoch != ctlEpoch) begin
          ctlSeenEpoch = ctlEpoch;
          ctlAttempts  = 0;
        end
        ctlNk = (ctlAttempts < ctlNacks);
        ctlAttempts++;
        ctlN = 0;
        while (oI2C_GO && (ctlHang || ctlN < ctlLat)) begin
          @(posedge iCLK);
          ctlN++;
        end
        if (oI2C_GO) begin
          #1;
          iI2C_END = 1'b1;
          iI2C_ACK = ctlNk;
          while (oI2C_GO) @(posedge iCLK);
          repeat (3) @(posedge iCLK);
          #1;
          iI2C_END = 1'b0;
          iI2C_ACK = 1'b0;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] mkCmd(input logic [7:0] s, input logic [7:0] u,
                                              input logic [7:0] d);
    logic [DATA_W-1:0] c;
    c = '0;
    c[SLAVE_MSB:SLAVE_LSB] = s;
    c[SUB_MSB:SUB_LSB]     = u;
    c[DAT_MSB:DAT_LSB]     = d;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a falling edge; drives the request there.
  task automatic transact(input string tag, input logic [N_REQ-1:0] valids,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                          input int nacks, input bit hang, input int lat, input bit keep);
    int g, idx, expPulses, readyCnt, readyLat, goHigh, lastFall, doneCyc, minGap;
    bit expErr, gotDone, dataStable, goPrev, busyAtDone;
    int rises[$];
    logic [N_REQ-1:0] oh, readyVec, doneVec, errVec;
    logic [DATA_W-1:0] expData, goData;

    g = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (mPtr + k) % N_REQ;
      if (g < 0 && ((valids >> idx) & 1) != 0) g = idx;
    end
    mPtr    = g;
    oh      = N_REQ'(1) << g;
    expData = (g == 0) ? d0 : d1;
    if (hang) begin
      expPulses = 1;
      expErr    = 1'b1;
    end else begin
`ifdef I2C_ARB_RETRY_EN
      expPulses = ((nacks < MAX_RETRY) ? nacks : MAX_RETRY) + 1;
      expErr    = (nacks > MAX_RETRY);
`else
      expPulses = 1;
      expErr    = (nacks > 0);
`endif
    end

    ctlNacks = nacks;
    ctlHang  = hang;
    ctlLat   = lat;
    ctlEpoch++;
    req_data  = {d1, d0};
    req_valid = valids;

    readyCnt = 0; readyLat = 0; goHigh = 0; lastFall = 0; doneCyc = 0;
    gotDone = 0; dataStable = 1; goPrev = 0; busyAtDone = 0;
    readyVec = '0; doneVec = '0; errVec = '0; goData = '0;
    for (int c = 1; c <= 3000 && !gotDone; c++) begin
      @(negedge iCLK);
      if (oI2C_GO && !goPrev) begin
        rises.push_back(c);
        if (rises.size() == 1) goData = oI2C_DATA;
        if (oI2C_DATA !== expData) dataStable = 0;
      end
      if (!oI2C_GO && goPrev) lastFall = c;
      goPrev = oI2C_GO;
      if (oI2C_GO) goHigh++;
      if (|req_ready) begin
        readyCnt++;
        readyVec = req_ready;
        if (readyCnt == 1) readyLat = c;
        if (!keep) req_valid = '0;
      end
      if (|rsp_done) begin
        gotDone    = 1;
        doneCyc    = c;
        doneVec    = rsp_done;
        errVec     = rsp_err;
        busyAtDone = busy;
      end
    end

    chk({tag, "_done_seen"}, gotDone, 1);
    chk({tag, "_ready"}, readyVec, oh);
    chk({tag, "_ready_lat"}, readyLat, 1);
    chk({tag, "_ready_cnt"}, readyCnt, 1);
    chk({tag, "_go_data"}, goData, expData);
    chk({tag, "_data_stable"}, dataStable, 1);
    chk({tag, "_go_pulses"}, rises.size(), expPulses);
    chk({tag, "_done"}, doneVec, oh);
    chk({tag, "_err"}, errVec, expErr ? oh : '0);
    chk({tag, "_busy_at_done"}, busyAtDone, 1);
    if (expPulses > 1) begin
      minGap = 1000000;
      for (int i = 1; i < rises.size(); i++)
        if (rises[i] - rises[i-1] < minGap) minGap = rises[i] - rises[i-1];
      chk({tag, "_backoff_gap"}, minGap >= BACKOFF_CYC, 1);
    end
    if (hang)
      chk({tag, "_timeout_len"}, goHigh >= TIMEOUT_CYC && goHigh <= TIMEOUT_CYC + 3, 1);
    else
      chk({tag, "_resp_lat"}, (doneCyc - lastFall) < BACKOFF_CYC, 1);

    @(negedge iCLK);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_1cyc"}, rsp_done, 0);
  endtask

  initial begin : main
    logic [DATA_W-1:0] a, b;
    int nv;
    bit seen;

    ctlEpoch  = 0;
    ctlNacks  = 0;
    ctlLat    = 20;
    ctlHang   = 0;
    mPtr      = N_REQ - 1;
    iRST      = 1'b1;
    req_valid = '0;
    req_data  = '0;

    repeat (3) @(negedge iCLK);
    chk("rst_go", oI2C_GO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", oI2C_DATA, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_err", rsp_err, 0);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("idle_busy", busy, 0);
    chk("idle_go", oI2C_GO, 0);

    transact("single", 2'b01, mkCmd(CODEC_SLAVE_ADDR, 8'h0C, 8'h00), '0, 0, 0, 40, 0);

    a = mkCmd(CODEC_SLAVE_ADDR, 8'h04, 8'h7B);
    b = mkCmd(CODEC_SLAVE_ADDR, 8'h06, 8'h7B);
    transact("fair0", 2'b11, a, b, 0, 0, 12, 1);
    transact("fair1", 2'b11, a, b, 0, 0, 12, 1);
    transact("fair2", 2'b11, a, b, 0, 0, 12, 1);
    transact("fair3", 2'b11, a, b, 0, 0, 12, 0);

    transact("nack1", 2'b01, mkCmd(DECODER_SLAVE_ADDR, 8'h0A, 8'h11), '0, 1, 0, 10, 0);
    transact("nack2_ack", 2'b10, '0, mkCmd(CODEC_SLAVE_ADDR, 8'h08, 8'h12), 2, 0, 10, 0);
    transact("nack4", 2'b01, mkCmd(CODEC_SLAVE_ADDR, 8'h0E, 8'h42), '0, 4, 0, 8, 0);

    transact("timeout", 2'b10, '0, mkCmd(DECODER_SLAVE_ADDR, 8'h15, 8'h00), 0, 1, 0, 0);
    transact("after_to", 2'b11, mkCmd(CODEC_SLAVE_ADDR, 8'h10, 8'h01),
             mkCmd(CODEC_SLAVE_ADDR, 8'h12, 8'h02), 0, 0, 15, 0);

    for (int i = 0; i < 8; i++) begin
      nv = $urandom_range(1, 3);
      a = mkCmd(($urandom_range(0, 1) == 0) ? CODEC_SLAVE_ADDR : DECODER_SLAVE_ADDR,
                8'($urandom), 8'($urandom));
      b = mkCmd(($urandom_range(0, 1) == 0) ? CODEC_SLAVE_ADDR : DECODER_SLAVE_ADDR,
                8'($urandom), 8'($urandom));
      transact($sformatf("rnd%0d", i), N_REQ'(nv), a, b, $urandom_range(0, 5),
               ($urandom_range(0, 9) == 0), $urandom_range(3, 40), 0);
    end

    // abort a requester-0 transfer mid-ISSUE
    ctlNacks  = 0;
    ctlHang   = 0;
    ctlLat    = 100;
    ctlEpoch++;
    req_data  = {mkCmd(CODEC_SLAVE_ADDR, 8'h02, 8'h55), mkCmd(CODEC_SLAVE_ADDR, 8'h00, 8'h17)};
    req_valid = 2'b01;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge iCLK);
      if (oI2C_GO) seen = 1;
    end
    chk("midrst_go_seen", seen, 1);
    req_valid = '0;
    repeat (5) @(negedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("midrst_go", oI2C_GO, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", oI2C_DATA, 0);
    chk("midrst_done", rsp_done, 0);
    chk("midrst_ready", req_ready, 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    mPtr = N_REQ - 1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge iCLK);
      if (|rsp_done || oI2C_GO) seen = 1;
    end
    chk("midrst_quiet", seen, 0);
    transact("post_rst", 2'b11, mkCmd(CODEC_SLAVE_ADDR, 8'h0C, 8'h01),
             mkCmd(DECODER_SLAVE_ADDR, 8'h0C, 8'h02), 0, 0, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares the single DE2 I2C write controller between N_REQ command sources, e.g. the boot-time codec/decoder config ROM and a runtime volume/mute controller.
- Each source offers 24-bit {slave_addr, sub_addr, data} write commands.
- The block round-robin arbitrates, sequences the controller's GO/END/ACK handshake, retries NACKed transfers, enforces a timeout, and returns a done/error pulse to the owning requester.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_W, 24, command width {slave[7:0], sub[7:0], data[7:0]}
- MAX_RETRY, 3, extra attempts after a NACK (0..15)
- BACKOFF_CYC, 1024, iCLK cycles idle between a NACK and its retry
- TIMEOUT_CYC, 2000000, iCLK cycles allowed for END per phase before abort

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  command pending, one bit per requester
- req_data  in  N_REQ*DATA_W  commands; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-cycle pulse: command i accepted
- rsp_done  out  N_REQ  one-cycle pulse: command i finished
- rsp_err  out  N_REQ  valid with rsp_done; 1 = failed (NACK exhausted or timeout)
- busy  out  1  a transfer is owned
- oI2C_DATA  out  DATA_W  command to controller
- oI2C_GO  out  1  controller start
- iI2C_END  in  1  controller transfer complete; slow-clock domain
- iI2C_ACK  in  1  controller ack result; 1 = NACK; slow-clock domain

Behaviour:
- Reset values:
  - All outputs 0, including oI2C_DATA.
  - State IDLE, retry count 0.
  - Round-robin pointer = N_REQ-1, so requester 0 wins the first arbitration.
- Synchronisation: iI2C_END and iI2C_ACK each pass through a 2-flop synchroniser. All decisions use the synchronised values (end_s, ack_s).
- IDLE:
  - If any req_valid: grant the first set bit at index ptr+1, ptr+2, ... (mod N_REQ).
  - Latch that requester's req_data into oI2C_DATA.
  - Pulse req_ready[g] the same cycle; set ptr=g; go to ISSUE.
  - Grant latency from valid to ready is 1 cycle.
  - A requester may drop req_valid before ready with no effect.
  - Requester data must be stable while valid.
- ISSUE:
  - oI2C_GO=1. Wait for end_s=1, then go to EVAL.
  - If the timeout counter reaches TIMEOUT_CYC: GO=0, go to RESP with err=1.
- EVAL: capture ack_s, GO=0, go to RELEASE.
- RELEASE:
  - Wait for end_s=0, with the same timeout → RESP err=1.
  - If captured ack=0: RESP err=0.
  - If captured ack=1 and retries<MAX_RETRY: retries+1, go to BACKOFF.
  - Otherwise: RESP err=1.
- BACKOFF: count BACKOFF_CYC cycles with GO=0, then go to ISSUE. oI2C_DATA is unchanged.
- RESP:
  - rsp_done[g]=1 for exactly 1 cycle; rsp_err[g] carries the result.
  - Clear the retry count; go to IDLE.
  - A new grant can occur the following cycle.
- busy=1 in every state except IDLE.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYC+1).
  - Cleared on each entry to ISSUE and RELEASE.
  - Saturates; never wraps.
- Ownership:
  - Requests arriving mid-transfer wait; the owner is never preempted.
  - req_valid from the owner during a transfer is ignored until IDLE.
- Reset mid-transfer: immediate return to reset values. GO drops asynchronously. No rsp_done for the aborted command.
- If iI2C_END is already high on entry to ISSUE (stale), it is treated as the completion. Upstream guarantees END low while GO low.

Optional Feature:
- Macro: I2C_ARB_RETRY_EN
- Defined: NACK retry with BACKOFF as above.
- Undefined: MAX_RETRY and BACKOFF_CYC are ignored, the BACKOFF state and retry counter are not built, and any NACK goes straight to RESP with err=1.

Decomposition:
- Package i2c_arb_pkg holds:
  - State enum: IDLE, ISSUE, EVAL, RELEASE, BACKOFF, RESP.
  - Field-slice localparams: SLAVE_MSB/LSB, SUB_MSB/LSB, DAT_MSB/LSB.
  - Codec slave address 8'h34 and decoder slave address 8'h40 as named constants.
- One sub-module: rr_arbiter (N_REQ request vector + pointer → one-hot grant + index), purely combinational.
- Synchronisers are inline.

Test Plan:
- Single command: req_valid[0]=1, data 24'h34_0C00, model ACKs after 40 cycles → req_ready[0] next cycle; GO high until END; rsp_done[0]=1, rsp_err[0]=0; busy low after.
- Fairness: both requesters valid continuously with data 24'h34_047B and 24'h34_067B → grants alternate 0,1,0,1; each rsp_done matches its grant.
- NACK retry (macro on, MAX_RETRY=3): model NACKs twice then ACKs → 3 GO pulses ≥BACKOFF_CYC apart; one rsp_done, err=0. Model NACKs 4 times → 4 GO pulses, err=1.
- Macro off: single NACK → one GO pulse, rsp_err=1, no BACKOFF gap.
- Timeout: model never asserts END → GO drops after TIMEOUT_CYC cycles; rsp_done with err=1; next request serviced normally.
- Reset mid-ISSUE: assert iRST while GO=1 → GO, busy and all outputs 0 immediately; no rsp_done; first grant after release goes to requester 0.
